bf_stack_reader: RTL

- Consumer side of the bias-free neural predictor's recency stack; the stack block writes the stacks, this block reads them.
- On each prediction request it walks all DEPTH entries of the iterative stack: branch address, folded-history bit and position per entry.
- For each valid entry it hashes a weight-table index, issues a read to the weight SRAM and accumulates the signed weights into a perceptron sum.
- Emits a taken/not-taken prediction; sits between the recency stack and the fetch-stage prediction mux.

---
 rtl/bf_stack_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bf_stack_reader.sv
// bf_stack_reader
//   Read side of the bias-free perceptron predictor's recency stack. Each
//   prediction request scans all DEPTH stack entries from newest (DEPTH) to
//   oldest (1). Every non-empty entry is hashed into a weight-table index,
//   one weight read is issued for it, and the returned signed weight is
//   added to or subtracted from the perceptron sum. The entry's folded
//   history bit selects add or subtract. At the end the block emits a
//   taken/not-taken prediction.
//
//   Build option: define BF_READER_SAT_EN to saturate the accumulator at the
//   SUM_W signed range. Without it, the accumulator wraps in two's complement.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   start         prediction request, accepted only when idle
//   abort         flush; cancels a scan that is in flight
//   pc            fetch PC, captured when start is accepted
//   Stack_branch  per-entry branch address; entry DEPTH is the newest
//   Folded_hist   per-entry outcome bit (1 = add weight, 0 = subtract)
//   Pos           per-entry position
//   wt_req        weight read strobe (registered)
//   wt_idx        weight read index (registered)
//   wt_rdata      signed weight, valid the cycle after wt_req
//   busy          scan in progress
//   pred_valid    one-cycle prediction strobe
//   pred_taken    prediction (sum >= 0)
//   pred_sum      signed perceptron sum
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one entry per cycle, cnt = DEPTH..1
// DRAIN | last read is on wt_req; waiting for its weight
// DONE  | last weight is on wt_rdata; prediction is registered
module bf_stack_reader #(
  parameter int DEPTH  = 48,
  parameter int ADDR_W = 16,
  parameter int POS_W  = 6,
  parameter int IDX_W  = 10,
  parameter int WGT_W  = 8,
  parameter int SUM_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ADDR_W-1:0]             pc,
  input  logic [DEPTH:1][ADDR_W-1:0]    Stack_branch,
  input  logic [DEPTH:1]                Folded_hist,
  input  logic [DEPTH:1][POS_W-1:0]     Pos,
  output logic                          wt_req,
  output logic [IDX_W-1:0]              wt_idx,
  input  logic [WGT_W-1:0]              wt_rdata,
  output logic                          busy,
  output logic                          pred_valid,
  output logic                          pred_taken,
  output logic signed [SUM_W-1:0]       pred_sum
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  pc_q;
  logic              hist_req, hist_d, req_d;
  logic [SUM_W-1:0]  sum, sum_step, sum_acc;
  logic [SUM_W:0]    sum_wide, rdata_ext;
  logic              accept, flush, issue;
  logic [ADDR_W-1:0] entry_br;
  logic [POS_W-1:0]  entry_pos;
  logic [IDX_W-1:0]  entry_idx;
  logic              unused_bits;

  // Bit 0 of the address is not used in the hash, so the index is taken
  // from bits IDX_W..1 of the branch address and of the PC.
  assign entry_br  = Stack_branch[cnt];
  assign entry_pos = Pos[cnt];
  assign entry_idx = entry_br[IDX_W:1] ^ pc_q ^ (IDX_W'(entry_pos) << (IDX_W - POS_W));

  assign flush = abort && (state != IDLE);
  assign issue = (state == SCAN) && (entry_br != '0) && !flush;

  assign unused_bits = ^{pc[ADDR_W-1:IDX_W+1], pc[0], entry_br[ADDR_W-1:IDX_W+1],
                         entry_br[0], sum_wide[SUM_W]};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // busy stays high for the cycle after DONE, so a start arriving
        // in that cycle is ignored as well.
        if (start && !abort && !busy) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN:    if (cnt == CNT_W'(1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Accumulator step. One guard bit is enough to detect overflow, because
  // both operands fit in SUM_W signed bits.
  always_comb begin
    rdata_ext = {{(SUM_W + 1 - WGT_W){wt_rdata[WGT_W-1]}}, wt_rdata};
    sum_wide  = hist_d ? ({sum[SUM_W-1], sum} + rdata_ext)
                       : ({sum[SUM_W-1], sum} - rdata_ext);
`ifdef BF_READER_SAT_EN
    if (sum_wide[SUM_W] != sum_wide[SUM_W-1])
      sum_step = sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    else
      sum_step = sum_wide[SUM_W-1:0];
`else
    sum_step = sum_wide[SUM_W-1:0];
`endif
    sum_acc = req_d ? sum_step : sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      pc_q       <= '0;
      wt_req     <= 1'b0;
      wt_idx     <= '0;
      hist_req   <= 1'b0;
      hist_d     <= 1'b0;
      req_d      <= 1'b0;
      sum        <= '0;
      busy       <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_sum   <= '0;
    end else begin
      busy       <= (state != IDLE) && !flush;
      wt_req     <= issue;
      hist_req   <= Folded_hist[cnt] && issue;
      req_d      <= wt_req && !flush;
      hist_d     <= hist_req && !flush;
      pred_valid <= (state == DONE) && !flush;
      if (issue) wt_idx <= entry_idx;
      if (accept) begin
        pc_q <= pc[IDX_W:1];
        cnt  <= CNT_W'(DEPTH);
        sum  <= '0;
      end else begin
        if (state == SCAN && !flush) cnt <= cnt - CNT_W'(1);
        if (!flush) sum <= sum_acc;
      end
      if (state == DONE && !flush) begin
        pred_sum   <= sum_acc;
        pred_taken <= ~sum_acc[SUM_W-1];
      end
    end
  end

endmodule
